riscv_gshare_predictor: RTL and testbench
=========================================

# riscv_gshare_predictor

Parametrised direction predictor for the fetch stage. It generalises the fixed 2-bit counter scheme to configurable table depth, counter width and global-history length. It uses a gshare-indexed pattern history table (PHT) of saturating counters. It gives a registered taken/not-taken prediction one cycle after a fetch lookup and trains from resolved branches in execute.

## Interface
Parameters:
- ENTRIES, 256: PHT depth; power of two, ≥ 4. IDX_W = $clog2(ENTRIES).
- CTR_W, 2: counter width, 2..4.
- HIST_W, 8: global history length, 1..IDX_W.
- ADDR_W, 32: PC width.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- lookup_valid_i  in  1  fetch lookup request
- lookup_pc_i  in  ADDR_W  fetch PC
- predict_valid_o  out  1  prediction valid, one cycle after lookup
- predict_taken_o  out  1  predicted direction
- predict_idx_o  out  IDX_W  PHT index used; carried down the pipe
- update_valid_i  in  1  resolved control-flow instruction
- update_is_branch_i  in  1  conditional branch (only these train)
- update_taken_i  in  1  actual outcome
- update_idx_i  in  IDX_W  index returned from predict_idx_o
- init_busy_o  out  1  table initialisation in progress

## Operation
- FSM states: INIT, READY.
- Reset forces INIT with init pointer = 0 and GHR = 0.
- INIT:
  - Writes WEAK_NT = 2^(CTR_W-1)-1 to entry[ptr] each cycle and increments ptr.
  - Leaves for READY after entry ENTRIES-1, taking ENTRIES cycles in total.
  - Lookups return predict_valid_o=0; updates are dropped.
  - init_busy_o=1.
- READY:
  - Lookup index = lookup_pc_i[IDX_W+1:2] XOR {zero-extended GHR}.
  - Prediction = MSB of the counter.
- Training fires when update_valid_i & update_is_branch_i & READY:
  - Counter at update_idx_i increments if taken and decrements if not taken.
  - The counter saturates at 0 and at 2^CTR_W-1.
  - GHR <= {GHR[HIST_W-2:0], update_taken_i}. History is non-speculative, updated only at resolve.
- Non-branch updates (update_is_branch_i=0) change nothing.
- Lookup and update to the same index in the same cycle: the lookup reads the pre-update value (read-before-write). Both operations complete.
- rst_i asserted in any state, including mid-INIT or mid-update: back to INIT at ptr 0, GHR cleared, any in-flight prediction discarded.

## Timing
- Reset values:
  - predict_valid_o=0
  - predict_taken_o=0
  - predict_idx_o=0
  - init_busy_o=1
- Lookup latency is 1 cycle, and all outputs are registered. With no lookup in a cycle, predict_valid_o=0 next cycle and predict_taken_o=0.
- Full throughput: one lookup and one update every cycle, with no back-pressure.
- The counter write takes effect in the update cycle. A lookup one cycle later sees the new value.
- The GHR update is visible to a lookup issued the cycle after the update.
- init_busy_o falls on the first READY cycle, ENTRIES cycles after rst_i deasserts.
  - A lookup issued in that cycle is valid.
  - A lookup issued in the last INIT cycle is not.

## Configuration
- RISCV_BP_GSHARE_EN defined: gshare indexing as above; the GHR exists.
- RISCV_BP_GSHARE_EN undefined:
  - Bimodal indexing with index = lookup_pc_i[IDX_W+1:2].
  - The GHR is not instantiated and HIST_W is ignored.
  - All other behaviour is identical.

## Structure
- Shared pipeline types package gets:
  - bp_pred_t, a parametrised-width replacement for the fixed prediction struct: valid, taken, idx.
  - bp_state_e: BP_INIT, BP_READY.
  - Function ctr_weak_nt(CTR_W).
  - Function sat_inc_dec(ctr, dir, CTR_W).
- Sub-module riscv_bp_pht:
  - ENTRIES×CTR_W storage.
  - One synchronous read port and one write port, read-before-write.
  - INIT sweep and update writes are muxed outside it.
- Top level holds the FSM, init pointer, GHR, index hash and output registers.

## Test plan
- Reset then idle (ENTRIES=256, CTR_W=2): init_busy_o=1 for exactly 256 cycles. The first lookup after that returns predict_valid_o=1, taken=0 (counter 1).
- Bimodal saturation (macro off, pc=0x100): two taken updates give taken=1 (counter 3). A third taken update keeps counter=3. Two not-taken updates give taken=0 (counter 1).
- Gshare history (macro on, HIST_W=4): updates taken, taken, not-taken, taken give GHR=4'b1101. A lookup at pc=0x40 reports predict_idx_o = 0x10 ^ 0x0D = 0x1D.
- Same-index collision: lookup and taken update to counter=1 in one cycle gives taken=0. The same lookup next cycle gives taken=1.
- Drops: an update during INIT, and an update with update_is_branch_i=0 in READY, each leave counters and GHR unchanged.
- Mid-init reset: assert rst_i at ptr=100. init_busy_o stays 1 for a full 256 further cycles, and predictions are weakly-not-taken.

Source files
------------

// File: rtl/riscv_gshare_predictor_pkg.sv
// Shared types and helpers for the fetch-stage direction predictor.
//   bp_pred_t    : prediction record (valid, taken, PHT index), sized for the
//                  largest supported table; users narrow idx with a cast.
//   bp_state_e   : table state (BP_INIT sweep, BP_READY).
//   ctr_weak_nt  : weakly-not-taken reset value for a CTR_W-bit counter.
//   sat_inc_dec  : saturating +1/-1 of a CTR_W-bit counter.
package riscv_gshare_predictor_pkg;

   localparam int BP_IDX_MAX_W = 16;
   localparam int BP_CTR_MAX_W = 4;

   typedef struct packed {
      logic                    valid;
      logic                    taken;
      logic [BP_IDX_MAX_W-1:0] idx;
   } bp_pred_t;

   typedef enum logic {
      BP_INIT  = 1'b0,
      BP_READY = 1'b1
   } bp_state_e;

   function automatic logic [BP_CTR_MAX_W-1:0] ctr_weak_nt(input int ctr_w);
      return BP_CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
   endfunction

   // dir=1 counts up, dir=0 counts down; holds at 0 and at 2^ctr_w-1.
   function automatic logic [BP_CTR_MAX_W-1:0] sat_inc_dec(
      input logic [BP_CTR_MAX_W-1:0] ctr,
      input logic                    dir,
      input int                      ctr_w
   );
      logic [BP_CTR_MAX_W-1:0] max_v;
      max_v = BP_CTR_MAX_W'((1 << ctr_w) - 1);
      if (dir) begin
         return (ctr == max_v) ? ctr : ctr + BP_CTR_MAX_W'(1);
      end
      return (ctr == '0) ? ctr : ctr - BP_CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/riscv_gshare_predictor_pht.sv
// Pattern history table: ENTRIES x CTR_W saturating-counter storage.
// Ports:
//   clk                      clock
//   rd_en, rd_idx, rd_data   synchronous read port (data valid next cycle)
//   wr_en, wr_idx, wr_data   write port
//   wr_cur                   current contents at wr_idx, so the caller can form
//                            a read-modify-write value in the same cycle
// A read and a write to the same entry in one cycle return the old value.
module riscv_bp_pht #(
   parameter  int ENTRIES = 256,
   parameter  int CTR_W   = 2,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CTR_W-1:0] rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [CTR_W-1:0] wr_data,
   output logic [CTR_W-1:0] wr_cur
);

   logic [CTR_W-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign wr_cur = mem[wr_idx];

endmodule

// File: rtl/riscv_gshare_predictor.sv
// Fetch-stage branch direction predictor with a PHT of saturating counters.
// After reset the table is swept to weakly-not-taken, one entry per cycle.
// Build option: RISCV_BP_GSHARE_EN selects gshare indexing (PC xor global
// history); without it the index is the PC alone and no history is kept.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   lookup_valid_i/pc_i     fetch lookup
//   predict_valid/taken/idx registered prediction, one cycle after lookup
//   update_*                resolved instruction from execute (branches train)
//   init_busy_o             table sweep in progress
//
// state    | meaning
// BP_INIT  | writing weakly-not-taken to entry ptr; lookups/updates ignored
// BP_READY | predicting and training
module riscv_gshare_predictor
   import riscv_gshare_predictor_pkg::*;
#(
   parameter  int ENTRIES = 256,
   parameter  int CTR_W   = 2,
   parameter  int HIST_W  = 8,
   parameter  int ADDR_W  = 32,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lookup_valid_i,
   input  logic [ADDR_W-1:0] lookup_pc_i,
   output logic              predict_valid_o,
   output logic              predict_taken_o,
   output logic [IDX_W-1:0]  predict_idx_o,
   input  logic              update_valid_i,
   input  logic              update_is_branch_i,
   input  logic              update_taken_i,
   input  logic [IDX_W-1:0]  update_idx_i,
   output logic              init_busy_o
);

   bp_state_e        state_q, state_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] lookup_idx;
   logic             lookup_fire;
   logic             train_fire;

   logic             pht_wr_en;
   logic [IDX_W-1:0] pht_wr_idx;
   logic [CTR_W-1:0] pht_wr_data;
   logic [CTR_W-1:0] pht_cur;
   logic [CTR_W-1:0] pht_rd_data;

   logic             pred_valid_q;
   logic [IDX_W-1:0] pred_idx_q;
   bp_pred_t         pred;

   logic             unused_pc;
   logic             unused_rd_lo;

   assign lookup_fire = lookup_valid_i & (state_q == BP_READY);
   assign train_fire  = update_valid_i & update_is_branch_i & (state_q == BP_READY);

`ifdef RISCV_BP_GSHARE_EN
   logic [HIST_W-1:0] ghr_q;

   // History is architectural: shifted only when a branch resolves.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ghr_q <= '0;
      end else if (train_fire) begin
         ghr_q <= HIST_W'({ghr_q, update_taken_i});
      end
   end

   assign lookup_idx = lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
   localparam int unused_hist_w = HIST_W;

   assign lookup_idx = lookup_pc_i[IDX_W+1:2];
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= BP_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == BP_INIT) begin
            ptr_q <= ptr_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      init_busy_o = 1'b0;
      case (state_q)
         BP_INIT: begin
            init_busy_o = 1'b1;
            if (ptr_q == IDX_W'(ENTRIES - 1)) begin
               state_d = BP_READY;
            end
         end
         BP_READY: state_d = BP_READY;
         default:  state_d = BP_INIT;
      endcase
   end

   // The init sweep owns the write port until the table is ready.
   always_comb begin
      if (state_q == BP_INIT) begin
         pht_wr_en   = 1'b1;
         pht_wr_idx  = ptr_q;
         pht_wr_data = CTR_W'(ctr_weak_nt(CTR_W));
      end else begin
         pht_wr_en   = train_fire;
         pht_wr_idx  = update_idx_i;
         pht_wr_data = CTR_W'(sat_inc_dec(BP_CTR_MAX_W'(pht_cur), update_taken_i, CTR_W));
      end
   end

   riscv_bp_pht #(
      .ENTRIES (ENTRIES),
      .CTR_W   (CTR_W)
   ) u_pht (
      .clk     (clk_i),
      .rd_en   (lookup_fire),
      .rd_idx  (lookup_idx),
      .rd_data (pht_rd_data),
      .wr_en   (pht_wr_en),
      .wr_idx  (pht_wr_idx),
      .wr_data (pht_wr_data),
      .wr_cur  (pht_cur)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pred_valid_q <= 1'b0;
         pred_idx_q   <= '0;
      end else begin
         pred_valid_q <= lookup_fire;
         if (lookup_fire) begin
            pred_idx_q <= lookup_idx;
         end
      end
   end

   // The PHT read data is already registered; masking with the valid flop
   // forces taken low on cycles without a prediction.
   always_comb begin
      pred       = '0;
      pred.valid = pred_valid_q;
      pred.taken = pred_valid_q & pht_rd_data[CTR_W-1];
      pred.idx   = BP_IDX_MAX_W'(pred_idx_q);
   end

   assign predict_valid_o = pred.valid;
   assign predict_taken_o = pred.taken;
   assign predict_idx_o   = IDX_W'(pred.idx);

   assign unused_pc    = ^{lookup_pc_i[ADDR_W-1:IDX_W+2], lookup_pc_i[1:0]};
   assign unused_rd_lo = ^pht_rd_data[CTR_W-2:0];

endmodule

// File: tb/tb_riscv_gshare_predictor.sv
module tb_riscv_gshare_predictor;

   localparam int ENTRIES = 256;
   localparam int CTR_W   = 2;
   localparam int HIST_W  = 4;
   localparam int ADDR_W  = 32;
   localparam int IDX_W   = 8;
`ifdef RISCV_BP_GSHARE_EN
   localparam bit GSHARE = 1'b1;
`else
   localparam bit GSHARE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              lookup_valid_i = 1'b0;
   logic [ADDR_W-1:0] lookup_pc_i = '0;
   logic              predict_valid_o;
   logic              predict_taken_o;
   logic [IDX_W-1:0]  predict_idx_o;
   logic              update_valid_i = 1'b0;
   logic              update_is_branch_i = 1'b0;
   logic              update_taken_i = 1'b0;
   logic [IDX_W-1:0]  update_idx_i = '0;
   logic              init_busy_o;

   always #5 clk = ~clk;

   riscv_gshare_predictor #(
      .ENTRIES(ENTRIES), .CTR_W(CTR_W), .HIST_W(HIST_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .lookup_valid_i     (lookup_valid_i),
      .lookup_pc_i        (lookup_pc_i),
      .predict_valid_o    (predict_valid_o),
      .predict_taken_o    (predict_taken_o),
      .predict_idx_o      (predict_idx_o),
      .update_valid_i     (update_valid_i),
      .update_is_branch_i (update_is_branch_i),
      .update_taken_i     (update_taken_i),
      .update_idx_i       (update_idx_i),
      .init_busy_o        (init_busy_o)
   );

   typedef struct {
      bit          lk;
      bit          raw;
      logic [31:0] pc;
      logic [7:0]  tgt;
      bit          up;
      bit          br;
      bit          tk;
      logic [7:0]  uidx;
      bit          rst;
      int          want_v;
      int          want_t;
   } op_t;

   typedef struct {
      logic       valid;
      logic       taken;
      logic [7:0] idx;
      logic       busy;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model
   logic [1:0] m_ctr [ENTRIES];
   logic [3:0] m_ghr = '0;
   bit         m_ready = 1'b0;
   int         m_cnt = 0;

   function automatic logic [7:0] hash(input logic [31:0] pc);
      return pc[9:2] ^ (GSHARE ? {4'b0000, m_ghr} : 8'h00);
   endfunction

   function automatic logic [31:0] pc_for(input logic [7:0] tgt);
      logic [7:0] h;
      h = tgt ^ (GSHARE ? {4'b0000, m_ghr} : 8'h00);
      return {22'd0, h, 2'b00};
   endfunction

   function automatic op_t mk(input bit lk, input logic [7:0] tgt, input bit up,
                              input bit br, input bit tk, input logic [7:0] uidx);
      op_t o;
      o.lk = lk; o.raw = 1'b0; o.pc = '0; o.tgt = tgt; o.up = up; o.br = br;
      o.tk = tk; o.uidx = uidx; o.rst = 1'b0; o.want_v = -1; o.want_t = -1;
      return o;
   endfunction

   function automatic op_t idle();
      return mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
   endfunction

   function automatic op_t rst_op();
      op_t o;
      o = idle();
      o.rst = 1'b1;
      return o;
   endfunction

   task automatic drive(input op_t o);
      exp_t        e;
      logic [31:0] pc;
      pc = o.raw ? o.pc : pc_for(o.tgt);
      rst_i              = o.rst;
      lookup_valid_i     = o.lk;
      lookup_pc_i        = pc;
      update_valid_i     = o.up;
      update_is_branch_i = o.br;
      update_taken_i     = o.tk;
      update_idx_i       = o.uidx;
      e.idx   = hash(pc);
      e.valid = o.lk && m_ready && !o.rst;
      e.taken = e.valid && m_ctr[e.idx][1];
      @(posedge clk);
      if (o.rst) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         m_ghr   = '0;
      end else if (!m_ready) begin
         m_cnt++;
         if (m_cnt == ENTRIES) begin
            m_ready = 1'b1;
            for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 2'd1;
         end
      end else if (o.up && o.br) begin
         if (o.tk) begin
            if (m_ctr[o.uidx] != 2'd3) m_ctr[o.uidx] = m_ctr[o.uidx] + 2'd1;
         end else begin
            if (m_ctr[o.uidx] != 2'd0) m_ctr[o.uidx] = m_ctr[o.uidx] - 2'd1;
         end
         m_ghr = {m_ghr[2:0], o.tk};
      end
      e.busy = !m_ready;
      sb_q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      int   edges;
      op_t  o;
      repeat (2) begin
         drive(rst_op());
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, predict_idx_o, init_busy_o} !== {1'b0, 1'b0, 8'h00, 1'b1})
            $display("FAIL reset_state got v=%b t=%b idx=%h busy=%b required v=0 t=0 idx=00 busy=1",
                     predict_valid_o, predict_taken_o, predict_idx_o, init_busy_o);
         else n_pass++;
      end
      edges = 0;
      while (init_busy_o === 1'b1 && edges < 1000) begin
         drive(idle());
         e = sb_q.pop_front();
         edges++;
         n_checks++;
         if ({predict_valid_o, init_busy_o} !== {e.valid, e.busy})
            $display("FAIL init_sweep[%0d] got v=%b busy=%b required v=%b busy=%b",
                     edges, predict_valid_o, init_busy_o, e.valid, e.busy);
         else n_pass++;
      end
      n_checks++;
      if (edges != ENTRIES) $display("FAIL init_length got %0d cycles required %0d", edges, ENTRIES);
      else n_pass++;
      o = mk(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(o);
      e = sb_q.pop_front();
      n_checks++;
      if ({predict_valid_o, predict_taken_o, predict_idx_o} !== {1'b1, 1'b0, 8'h40})
         $display("FAIL first_lookup got v=%b t=%b idx=%h required v=1 t=0 idx=40",
                  predict_valid_o, predict_taken_o, predict_idx_o);
      else n_pass++;
   endtask

   // Runs a list of ops, checking every cycle against the model and any
   // absolute expectations attached to the op.
   task automatic test_bimodal_saturation();
      op_t  ops[8];
      exp_t e;
      ops[0] = mk(0, 8'h00, 1, 1, 1, 8'h40);
      ops[1] = mk(0, 8'h00, 1, 1, 1, 8'h40);
      ops[2] = mk(1, 8'h40, 0, 0, 0, 8'h00); ops[2].want_t = 1;
      ops[3] = mk(0, 8'h00, 1, 1, 1, 8'h40);
      ops[4] = mk(1, 8'h40, 0, 0, 0, 8'h00); ops[4].want_t = 1;
      ops[5] = mk(0, 8'h00, 1, 1, 0, 8'h40);
      ops[6] = mk(0, 8'h00, 1, 1, 0, 8'h40);
      ops[7] = mk(1, 8'h40, 0, 0, 0, 8'h00); ops[7].want_t = 0;
      for (int i = 0; i < 8; i++) begin
         drive(ops[i]);
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL saturation[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
         if (ops[i].want_t >= 0) begin
            n_checks++;
            if (predict_taken_o !== 1'(ops[i].want_t))
               $display("FAIL saturation_plan[%0d] got t=%b required t=%0d", i, predict_taken_o, ops[i].want_t);
            else n_pass++;
         end
      end
   endtask

   task automatic test_gshare_history();
      op_t  ops[5];
      exp_t e;
      ops[0] = mk(0, 8'h00, 1, 1, 1, 8'h33);
      ops[1] = mk(0, 8'h00, 1, 1, 1, 8'h33);
      ops[2] = mk(0, 8'h00, 1, 1, 0, 8'h33);
      ops[3] = mk(0, 8'h00, 1, 1, 1, 8'h33);
      ops[4] = mk(1, 8'h00, 0, 0, 0, 8'h00); ops[4].raw = 1'b1; ops[4].pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         drive(ops[i]);
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL history[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
      end
      n_checks++;
      if (predict_idx_o !== (GSHARE ? 8'h1D : 8'h10))
         $display("FAIL history_idx got %h required %h", predict_idx_o, (GSHARE ? 8'h1D : 8'h10));
      else n_pass++;
   endtask

   task automatic test_collision_and_drops();
      op_t  ops[6];
      exp_t e;
      ops[0] = mk(1, 8'h80, 1, 1, 1, 8'h80); ops[0].want_t = 0;
      ops[1] = mk(1, 8'h80, 0, 0, 0, 8'h00); ops[1].want_t = 1;
      ops[2] = mk(0, 8'h00, 1, 0, 0, 8'h80);
      ops[3] = mk(0, 8'h00, 1, 0, 0, 8'h80);
      ops[4] = mk(1, 8'h80, 0, 0, 0, 8'h00); ops[4].want_t = 1;
      ops[5] = mk(1, 8'h00, 0, 0, 0, 8'h00); ops[5].raw = 1'b1; ops[5].pc = 32'h40;
      for (int i = 0; i < 6; i++) begin
         drive(ops[i]);
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL collision[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
         if (e.valid) begin
            n_checks++;
            if (predict_idx_o !== e.idx)
               $display("FAIL collision_idx[%0d] got %h required %h", i, predict_idx_o, e.idx);
            else n_pass++;
         end
         if (ops[i].want_t >= 0) begin
            n_checks++;
            if (predict_taken_o !== 1'(ops[i].want_t))
               $display("FAIL collision_plan[%0d] got t=%b required t=%0d", i, predict_taken_o, ops[i].want_t);
            else n_pass++;
         end
      end
   endtask

   task automatic test_init_drop();
      op_t  o;
      exp_t e;
      drive(rst_op());
      void'(sb_q.pop_front());
      for (int i = 0; i < 300; i++) begin
         o = idle();
         if (i == 150) o = mk(1, 8'h05, 1, 1, 1, 8'h05);
         if (i == 280) o = mk(1, 8'h05, 0, 0, 0, 8'h00);
         drive(o);
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL init_drop[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
         if (i == 280) begin
            n_checks++;
            if ({predict_valid_o, predict_taken_o, predict_idx_o} !== {1'b1, 1'b0, 8'h05})
               $display("FAIL init_drop_plan got v=%b t=%b idx=%h required v=1 t=0 idx=05",
                        predict_valid_o, predict_taken_o, predict_idx_o);
            else n_pass++;
         end
      end
   endtask

   task automatic test_mid_init_reset();
      op_t  o;
      exp_t e;
      int   first_ready;
      repeat (3) begin
         drive(mk(0, 8'h00, 1, 1, 1, 8'h90));
         void'(sb_q.pop_front());
      end
      drive(rst_op());
      void'(sb_q.pop_front());
      repeat (100) begin
         drive(idle());
         void'(sb_q.pop_front());
      end
      drive(rst_op());
      void'(sb_q.pop_front());
      first_ready = -1;
      for (int i = 0; i < 257; i++) begin
         o = (i >= 254) ? mk(1, 8'h90, 0, 0, 0, 8'h00) : idle();
         drive(o);
         e = sb_q.pop_front();
         if (first_ready < 0 && init_busy_o === 1'b0) first_ready = i;
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL mid_init[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
         if (i == 255 || i == 256) begin
            n_checks++;
            if ({predict_valid_o, predict_taken_o} !== {(i == 256), 1'b0})
               $display("FAIL mid_init_edge[%0d] got v=%b t=%b required v=%0d t=0",
                        i, predict_valid_o, predict_taken_o, (i == 256));
            else n_pass++;
         end
      end
      n_checks++;
      if (first_ready != 255)
         $display("FAIL mid_init_length got ready after %0d cycles required 256", first_ready + 1);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      op_t  o;
      exp_t e;
      for (int i = 0; i < 400; i++) begin
         o = mk(($urandom_range(0, 3) != 0), 8'h10 + 8'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 8'h10 + 8'($urandom_range(0, 3)));
         if ($urandom_range(0, 4) == 0) begin
            o.raw = 1'b1;
            o.pc  = $urandom;
         end
         drive(o);
         e = sb_q.pop_front();
         n_checks++;
         if ({predict_valid_o, predict_taken_o, init_busy_o} !== {e.valid, e.taken, e.busy})
            $display("FAIL back_to_back[%0d] got v=%b t=%b busy=%b required v=%b t=%b busy=%b",
                     i, predict_valid_o, predict_taken_o, init_busy_o, e.valid, e.taken, e.busy);
         else n_pass++;
         if (e.valid) begin
            n_checks++;
            if (predict_idx_o !== e.idx)
               $display("FAIL back_to_back_idx[%0d] got %h required %h", i, predict_idx_o, e.idx);
            else n_pass++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 2'd1;
      #1;
      test_reset();
      test_bimodal_saturation();
      test_gshare_history();
      test_collision_and_drops();
      test_init_drop();
      test_mid_init_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
